// File: rtl/snake_game_ctrl_if.sv
// Control/handshake bundle between the snake game-flow controller and the
// food, render and snake-body units.
interface snake_game_ctrl_if #(
    parameter int SCORE_W = 8
);
    // Requests are level signals: food_req/render_req stay high until the unit
    // answers with a one-cycle food_ack/render_done. move_en is a single-cycle step.
    // collided/food_eaten are only sampled while the controller is in CHECK.
    logic                start;
    logic                pause;
    logic [1:0]          dir_in;
    logic                food_ack;
    logic                render_done;
    logic                collided;
    logic                food_eaten;
    logic                clear;
    logic                board_rst;
    logic                food_req;
    logic                render_req;
    logic                move_en;
    logic                game_over;
    logic [1:0]          dir_out;
    logic [SCORE_W-1:0]  score;
    logic [3:0]          level;
    logic [3:0]          lives_left;
    logic [3:0]          state_out;

    modport master (
        input  start, pause, dir_in, food_ack, render_done, collided, food_eaten,
        output clear, board_rst, food_req, render_req, move_en, game_over,
               dir_out, score, level, lives_left, state_out
    );

    modport slave (
        output start, pause, dir_in, food_ack, render_done, collided, food_eaten,
        input  clear, board_rst, food_req, render_req, move_en, game_over,
               dir_out, score, level, lives_left, state_out
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: lives, saturating score, score-driven speed
// levels with an internal move timer, pause and a reversal-rejecting direction latch.
module snake_game_ctrl #(
    parameter int SCORE_W       = 8,
    parameter int LIVES         = 3,
    parameter int TICK_BASE     = 50,
    parameter int TICK_STEP     = 5,
    parameter int LEVEL_MAX     = 7,
    parameter int PTS_PER_LEVEL = 4
) (
    input logic               clk,
    input logic               rst,
    snake_game_ctrl_if.master bus
);
    localparam int TIMER_W = $clog2(TICK_BASE + 1);
    localparam int PTS_W   = $clog2(PTS_PER_LEVEL + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_GENFOOD = 4'd2,
        S_RENDER  = 4'd3,
        S_WAIT    = 4'd4,
        S_MOVE    = 4'd5,
        S_CHECK   = 4'd6,
        S_PAUSE   = 4'd7,
        S_OVER    = 4'd8
    } state_t;

    state_t               state_q;
    logic [SCORE_W-1:0]   score_q;
    logic [3:0]           level_q;
    logic [3:0]           lives_q;
    logic [PTS_W-1:0]     pts_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [1:0]           dir_q;
    logic [1:0]           pend_q;

    logic [TIMER_W-1:0]   period_m1;
    logic                 capture_en;
    logic                 is_rev;
    logic [1:0]           pend_nxt;

    always_comb begin
        period_m1 = TIMER_W'(TICK_BASE - (int'(level_q) * TICK_STEP) - 1);
    end

    // A reversal keeps the vertical/horizontal axis but flips the sense.
    always_comb begin
        capture_en = (state_q != S_IDLE) && (state_q != S_PAUSE) && (state_q != S_OVER);
        is_rev     = (bus.dir_in[1] == dir_q[1]) && (bus.dir_in[0] != dir_q[0]);
        pend_nxt   = pend_q;
        if (capture_en && !is_rev) pend_nxt = bus.dir_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            score_q <= '0;
            level_q <= '0;
            lives_q <= 4'(LIVES);
            pts_q   <= '0;
            timer_q <= '0;
            dir_q   <= 2'b11;
            pend_q  <= 2'b11;
        end else begin
            pend_q <= pend_nxt;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (bus.start) begin
                        state_q <= S_START;
                        score_q <= '0;
                        level_q <= '0;
                        pts_q   <= '0;
                        lives_q <= 4'(LIVES);
                    end
                end
                S_START: begin
                    dir_q   <= 2'b11;
                    pend_q  <= 2'b11;
                    state_q <= S_GENFOOD;
                end
                S_GENFOOD: if (bus.food_ack) state_q <= S_RENDER;
                S_RENDER: begin
                    if (bus.render_done) begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.pause) begin
                        state_q <= S_PAUSE;
                    end else if (timer_q == period_m1) begin
                        // Commit the latched direction so dir_out is stable during move_en.
                        state_q <= S_MOVE;
                        dir_q   <= pend_nxt;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                S_PAUSE: if (bus.pause) state_q <= S_WAIT;
                S_MOVE:  state_q <= S_CHECK;
                S_CHECK: begin
                    if (bus.collided) begin
                        lives_q <= lives_q - 4'd1;
                        state_q <= (lives_q == 4'd1) ? S_OVER : S_START;
                    end else if (bus.food_eaten) begin
                        if (score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
                        if (pts_q == PTS_W'(PTS_PER_LEVEL - 1)) begin
                            pts_q <= '0;
                            if (level_q < 4'(LEVEL_MAX)) level_q <= level_q + 4'd1;
                        end else begin
                            pts_q <= pts_q + PTS_W'(1);
                        end
                        state_q <= S_GENFOOD;
                    end else begin
                        state_q <= S_RENDER;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.clear      = (state_q == S_IDLE);
    assign bus.board_rst  = (state_q == S_START);
    assign bus.food_req   = (state_q == S_GENFOOD);
    assign bus.render_req = (state_q == S_RENDER);
    assign bus.move_en    = (state_q == S_MOVE);
    assign bus.game_over  = (state_q == S_OVER);
    assign bus.dir_out    = dir_q;
    assign bus.score      = score_q;
    assign bus.level      = level_q;
    assign bus.lives_left = lives_q;
    assign bus.state_out  = state_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: scripted and randomized games driven against a
// rule-level game model; a monitor checks every step, board reset and game over.
module tb_snake_game_ctrl;
    localparam int SW = 3;
    localparam int LIVES_P = 2;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    snake_game_ctrl_if #(.SCORE_W(SW)) bus ();

    snake_game_ctrl #(
        .SCORE_W(SW), .LIVES(LIVES_P), .TICK_BASE(8), .TICK_STEP(2),
        .LEVEL_MAX(3), .PTS_PER_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // record: kind[35:34] wait[33:26] pause[25:18] dir[17:16] score[15:12] level[11:8] lives[7:4]
    logic [35:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    function automatic logic [35:0] rec(input int kind, input int wl, input int pl,
                                        input int d, input int sc, input int lv, input int li);
        logic [35:0] r;
        r = {2'(kind), 8'(wl), 8'(pl), 2'(d), 4'(sc), 4'(lv), 4'(li), 4'd0};
        return r;
    endfunction

    // ---------------- game model ----------------
    int         m_eaten;
    int         m_lives;
    logic [1:0] m_cur;
    logic [1:0] m_pend;
    logic [1:0] dir_held;

    function automatic int m_level();
        int l;
        l = m_eaten / 2;
        return (l > 3) ? 3 : l;
    endfunction

    function automatic int m_score();
        return (m_eaten > 7) ? 7 : m_eaten;
    endfunction

    function automatic int m_period();
        return 8 - 2 * m_level();
    endfunction

    function automatic bit rev(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // ---------------- responders (food / render units) ----------------
    int render_hold;

    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 3;
        bus.food_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.food_ack = 1'b0;
            if (bus.food_req && !rst) begin
                if (cnt >= lat) begin
                    bus.food_ack = 1'b1;
                    cnt = 0;
                    lat = $urandom_range(0, 4);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 2;
        bus.render_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.render_done = 1'b0;
            if (bus.render_req && !rst && render_hold == 0) begin
                if (cnt >= lat) begin
                    bus.render_done = 1'b1;
                    cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int wait_cnt;
        int pause_cnt;
        logic go_prev;
        logic [35:0] e;
        wait_cnt = 0;
        pause_cnt = 0;
        go_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.state_out == 4'd3) begin
                wait_cnt = 0;
                pause_cnt = 0;
            end
            if (bus.state_out == 4'd4) wait_cnt++;
            if (bus.state_out == 4'd7) begin
                pause_cnt++;
                chk("pause_quiet",
                    int'({bus.food_req, bus.render_req, bus.move_en, bus.board_rst,
                          bus.clear, bus.game_over}), 0);
            end
            if (bus.move_en || bus.board_rst || (bus.game_over && !go_prev)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(bus.state_out), 99);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.move_en) begin
                        chk("event_kind_move", 0, int'(e[35:34]));
                        chk("wait_len", wait_cnt, int'(e[33:26]));
                        chk("pause_len", pause_cnt, int'(e[25:18]));
                        chk("dir_out", int'(bus.dir_out), int'(e[17:16]));
                    end else if (bus.board_rst) begin
                        chk("event_kind_start", 1, int'(e[35:34]));
                    end else begin
                        chk("event_kind_over", 2, int'(e[35:34]));
                    end
                    chk("score", int'(bus.score), int'(e[15:12]));
                    chk("level", int'(bus.level), int'(e[11:8]));
                    chk("lives", int'(bus.lives_left), int'(e[7:4]));
                end
            end
            go_prev = bus.game_over;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [3:0] code, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (bus.state_out == code) return;
            @(negedge clk);
        end
        chk({"timeout_", name}, int'(bus.state_out), int'(code));
        finish_test();
    endtask

    task automatic start_game(input logic [3:0] from_state);
        wait_state(from_state, 400, "start_from");
        bus.start = 1'b1;
        m_eaten = 0;
        m_lives = LIVES_P;
        m_cur = 2'b11;
        m_pend = 2'b11;
        exp_q.push_back(rec(1, 0, 0, 0, 0, 0, LIVES_P));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic play_round(input bit eat, input bit coll, input int pause_at, input int plen,
                              input int ndir, input logic [1:0] d0, input logic [1:0] d1,
                              input bit start_noise);
        int cyc;
        int wl;
        wait_state(4'd4, 400, "reach_wait");
        if (!rev(dir_held, m_cur)) m_pend = dir_held;
        if (ndir > 0 && !rev(d0, m_cur)) m_pend = d0;
        if (ndir > 1 && !rev(d1, m_cur)) m_pend = d1;
        m_cur = m_pend;
        wl = m_period() + ((pause_at >= 0) ? 1 : 0);
        exp_q.push_back(rec(0, wl, (pause_at >= 0) ? plen : 0, m_cur, m_score(), m_level(), m_lives));
        cyc = 0;
        if (start_noise) bus.start = 1'b1;
        for (int i = 0; i < ndir; i++) begin
            bus.dir_in = (i == 0) ? d0 : d1;
            dir_held = bus.dir_in;
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        if (start_noise && ndir == 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        if (pause_at >= 0) begin
            repeat (pause_at - cyc) @(negedge clk);
            bus.pause = 1'b1;
            @(negedge clk);
            bus.pause = 1'b0;
            repeat (plen - 1) @(negedge clk);
            bus.pause = 1'b1;
            @(negedge clk);
            bus.pause = 1'b0;
        end
        wait_state(4'd5, 100, "reach_move");
        bus.collided = coll;
        bus.food_eaten = eat;
        if (coll) begin
            m_lives--;
            if (m_lives == 0) begin
                exp_q.push_back(rec(2, 0, 0, 0, m_score(), m_level(), 0));
            end else begin
                exp_q.push_back(rec(1, 0, 0, 0, m_score(), m_level(), m_lives));
                m_cur = 2'b11;
                m_pend = 2'b11;
            end
        end else if (eat) begin
            m_eaten++;
        end
        @(negedge clk);
        @(negedge clk);
        bus.collided = 1'b0;
        bus.food_eaten = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(bus.state_out), 0);
        chk({tag, "_clear"}, int'(bus.clear), 1);
        chk({tag, "_reqs"}, int'({bus.board_rst, bus.food_req, bus.render_req,
                                  bus.move_en, bus.game_over}), 0);
        chk({tag, "_score"}, int'(bus.score), 0);
        chk({tag, "_level"}, int'(bus.level), 0);
        chk({tag, "_lives"}, int'(bus.lives_left), LIVES_P);
        chk({tag, "_dir"}, int'(bus.dir_out), 3);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        checks = 0;
        fails = 0;
        render_hold = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.dir_in = 2'b11;
        bus.collided = 1'b0;
        bus.food_eaten = 1'b0;
        dir_held = 2'b11;
        m_eaten = 0;
        m_lives = LIVES_P;
        m_cur = 2'b11;
        m_pend = 2'b11;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_clear", int'(bus.clear), 1);

        // Scripted game: level ramp, direction latch, pause, saturation, lives.
        start_game(4'd0);
        play_round(1, 0, -1, 0, 0, 2'b00, 2'b00, 0);
        play_round(1, 0, 3, 20, 2, 2'b10, 2'b00, 0);
        play_round(1, 0, -1, 0, 1, 2'b01, 2'b00, 0);
        for (int i = 0; i < 6; i++) play_round(1, 0, -1, 0, 0, 2'b00, 2'b00, 0);
        play_round(1, 0, -1, 0, 0, 2'b00, 2'b00, 0);
        play_round(1, 1, -1, 0, 0, 2'b00, 2'b00, 0);
        play_round(0, 0, -1, 0, 0, 2'b00, 2'b00, 0);
        play_round(0, 1, -1, 0, 0, 2'b00, 2'b00, 0);
        start_game(4'd8);

        // Randomized games.
        for (int r = 0; r < 40; r++) begin
            bit eat;
            bit coll;
            bit noise;
            int nd;
            int pa;
            int per;
            if (m_lives == 0) start_game(4'd8);
            per = m_period();
            eat = ($urandom_range(0, 1) == 1);
            coll = ($urandom_range(0, 6) == 0);
            noise = ($urandom_range(0, 3) == 0);
            nd = noise ? 0 : $urandom_range(0, 2);
            pa = -1;
            if (!noise && nd <= per - 1 && $urandom_range(0, 3) == 0)
                pa = $urandom_range(nd, per - 1);
            play_round(eat, coll, pa, $urandom_range(2, 10), nd,
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), noise);
        end
        if (m_lives == 0) start_game(4'd8);

        // Reset in the middle of the render handshake.
        render_hold = 1;
        wait_state(4'd3, 400, "reach_render");
        @(negedge clk);
        chk("render_req_held", int'(bus.render_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        render_hold = 0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", int'(bus.state_out), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        finish_test();
    end

    initial begin
        #400000;
        chk("watchdog", 0, 1);
        finish_test();
    end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Parametrised next-generation game-flow controller for the snake game.
- Sequences clear → board reset → food generation → render → timed move → collision/food check, using explicit request/acknowledge handshakes with the food, render and snake-body units.
- Adds features the first controller lacks:
  - multiple lives,
  - saturating score,
  - score-driven speed levels with an internal move timer,
  - pause,
  - reversal-rejecting direction latch.

Parameters:
- SCORE_W, 8: score register width.
- LIVES, 3: lives per game (1..15).
- TICK_BASE, 50: WAIT length in cycles at level 0.
- TICK_STEP, 5: WAIT cycles removed per level. Constraint: TICK_BASE > LEVEL_MAX*TICK_STEP.
- LEVEL_MAX, 7: highest level (1..15).
- PTS_PER_LEVEL, 4: foods eaten per level-up (≥1).

Ports:
- clk, in, 1: system clock, all state changes on its rising edge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin/restart game pulse.
- pause, in, 1: pause toggle pulse.
- dir_in, in, 2: requested direction (00 up, 01 down, 10 left, 11 right).
- food_ack, in, 1: food unit done placing food.
- render_done, in, 1: frame redraw complete.
- collided, in, 1: head hit wall/body; valid in CHECK.
- food_eaten, in, 1: head on food; valid in CHECK.
- clear, out, 1: screen clear, high in IDLE.
- board_rst, out, 1: snake/board reset, high in START.
- food_req, out, 1: high in GENFOOD.
- render_req, out, 1: high in RENDER.
- move_en, out, 1: one-cycle step pulse, high in MOVE.
- game_over, out, 1: high in OVER.
- dir_out, out, 2: committed direction.
- score, out, SCORE_W: current score.
- level, out, 4: current level.
- lives_left, out, 4: remaining lives.
- state_out, out, 4: state code for debug.

Behaviour:
- Reset state on rst=1 (overrides everything, any state, mid-handshake included):
  - state=IDLE, score=0, level=0, lives_left=LIVES, pts counter=0, timer=0, dir_cur=11.
  - All pulse/req outputs are 0 except clear=1.
- State encoding: IDLE 0, START 1, GENFOOD 2, RENDER 3, WAIT 4, MOVE 5, CHECK 6, PAUSE 7, OVER 8. state_out shows the registered state. All outputs are decoded from registered state/registers (Moore).
- IDLE: start=1 → START. On this transition: score=0, level=0, pts=0, lives_left=LIVES.
- START: 1 cycle. Sets dir_cur=11 and clears the pending direction. → GENFOOD.
- GENFOOD: food_req held high until food_ack=1. food_ack in the same cycle as entry counts. → RENDER on the next edge.
- RENDER: render_req held high until render_done=1. → WAIT, timer=0.
- WAIT:
  - timer increments each cycle.
  - When timer == period−1 → MOVE, so WAIT lasts exactly period cycles.
  - period = TICK_BASE − level*TICK_STEP.
  - A pause pulse in WAIT → PAUSE, and the timer is held.
- PAUSE: all req/pulse outputs 0; timer frozen. Pause pulse → WAIT, resuming at the held timer value.
- Pause pulses in any other state are ignored.
- MOVE: 1 cycle. dir_cur ← pending direction before the pulse, so dir_out is valid while move_en=1. → CHECK.
- Direction latch:
  - In any state except PAUSE/OVER/IDLE, dir_in is captured into pending each cycle, unless it is a reversal of dir_cur.
  - Reversal rule: same bit1, different bit0. Reversals are dropped.
  - The last non-reversal value seen before MOVE wins.
- CHECK (1 cycle, priority collided > food_eaten):
  - collided=1: lives_left−1.
    - Result 0 → OVER.
    - Otherwise → START. Score and level are kept.
  - Else food_eaten=1:
    - score+1, saturating at 2^SCORE_W−1.
    - pts+1; when pts reaches PTS_PER_LEVEL, pts=0 and level+1, saturating at LEVEL_MAX.
    - → GENFOOD.
  - Else → RENDER.
- OVER: game_over=1. Score, level and lives are held for display. start=1 → START with the same counter re-init as from IDLE.
- The start input is ignored in all other states.

Test Plan:
- Params TICK_BASE=8, TICK_STEP=2, LEVEL_MAX=3, PTS_PER_LEVEL=2, LIVES=2.
- Reset, start pulse: board_rst 1 cycle → food_req until ack (ack after 3 cycles) → render_req until render_done → WAIT lasts exactly 8 cycles → move_en one cycle, dir_out=11.
- Feed food_eaten in 7 consecutive CHECKs → score 1..7, level 0,1,1,2,2,3,3. WAIT lengths: 8 cycles at level 0, then 6, 4, 2, and 2 at level 3.
- During WAIT apply dir_in=10 (reversal of 11) then dir_in=00 → next move has dir_out=00. Then dir_in=01 (reversal) → ignored, dir_out stays 00.
- Pause pulse at WAIT cycle 3, hold 20 cycles, pause pulse again → exactly 5 more WAIT cycles before move_en. No move_en/req during PAUSE.
- collided and food_eaten both 1 in CHECK → lives 2→1, score unchanged, state START. Second collision → OVER, game_over=1. Start pulse → score=0, level=0, lives=2.
- Assert rst while render_req=1 → next cycle IDLE, clear=1, render_req=0. SCORE_W=3 with 9 foods → score saturates at 7.
